// File: rtl/camera_init_sequencer.sv
// Camera bring-up controller: timed power/reset sequence, one init handshake with the
// register-table writer, completion detection, settle delay, and timeout-driven retries.
module camera_init_sequencer #(
  parameter int PWDN_CYCLES    = 100000,
  parameter int RESET_CYCLES   = 100000,
  parameter int BOOT_CYCLES    = 2000000,
  parameter int SETTLE_CYCLES  = 1000000,
  parameter int TIMEOUT_CYCLES = 50000000,
  parameter int MAX_RETRIES    = 2,
  parameter int AUTO_START     = 1,
  localparam int RC_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1
) (
  input  logic            clk_in,
  input  logic            rst_n_in,
  input  logic            start_in,
  output logic            init_valid_out,
  input  logic            init_ready_in,
  output logic            cam_pwdn_out,
  output logic            cam_rst_n_out,
  output logic            busy_out,
  output logic            done_out,
  output logic            error_out,
  output logic [RC_W-1:0] retry_count_out
);

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int MAX_CYC = max2(max2(max2(PWDN_CYCLES, RESET_CYCLES),
                                     max2(BOOT_CYCLES, SETTLE_CYCLES)), TIMEOUT_CYCLES);
  localparam int CNT_W   = $clog2(MAX_CYC) + 1;

  localparam logic [CNT_W-1:0] ONE         = CNT_W'(1);
  localparam logic [CNT_W-1:0] PWDN_LAST   = CNT_W'(PWDN_CYCLES - 1);
  localparam logic [CNT_W-1:0] RESET_LAST  = CNT_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] BOOT_LAST   = CNT_W'(BOOT_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST    = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [RC_W-1:0]  RC_MAX      = RC_W'(MAX_RETRIES);

  typedef enum logic [3:0] {
    IDLE, PWDN, RESET, BOOT, REQ, RUN, SETTLE, DONE, FAIL
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             seen_low;
  logic [RC_W-1:0]  retry;
  logic [5:0]       pins_q;
  logic             tmo;

  // Output image of each state: {pwdn, rst_n, valid, busy, done, error}
  function automatic logic [5:0] pins(input state_t s);
    case (s)
      PWDN:    return 6'b100100;
      RESET:   return 6'b000100;
      BOOT:    return 6'b010100;
      REQ:     return 6'b011100;
      RUN:     return 6'b010100;
      SETTLE:  return 6'b010100;
      DONE:    return 6'b010010;
      FAIL:    return 6'b100001;
      default: return 6'b100000;
    endcase
  endfunction

  // The timeout count spans REQ and RUN; a late handshake can push it past the last value.
  assign tmo = (cnt >= TMO_LAST);

  assign {cam_pwdn_out, cam_rst_n_out, init_valid_out, busy_out, done_out, error_out} = pins_q;
  assign retry_count_out = retry;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state    <= IDLE;
      pins_q   <= pins(IDLE);
      cnt      <= '0;
      seen_low <= 1'b0;
      retry    <= '0;
    end else begin
      case (state)
        IDLE: if (AUTO_START != 0 || start_in) begin
          state <= PWDN; pins_q <= pins(PWDN); cnt <= '0; retry <= '0;
        end
        PWDN: if (cnt == PWDN_LAST) begin
          state <= RESET; pins_q <= pins(RESET); cnt <= '0;
        end else cnt <= cnt + ONE;
        RESET: if (cnt == RESET_LAST) begin
          state <= BOOT; pins_q <= pins(BOOT); cnt <= '0;
        end else cnt <= cnt + ONE;
        BOOT: if (cnt == BOOT_LAST) begin
          state <= REQ; pins_q <= pins(REQ); cnt <= '0;
        end else cnt <= cnt + ONE;
        REQ, RUN: begin
          if (state == REQ && init_ready_in) begin
            state <= RUN; pins_q <= pins(RUN); seen_low <= 1'b0; cnt <= cnt + ONE;
          end else if (state == RUN && init_ready_in && seen_low) begin
            state <= SETTLE; pins_q <= pins(SETTLE); cnt <= '0;
          end else begin
            if (state == RUN && !init_ready_in) seen_low <= 1'b1;
            if (tmo) begin
              cnt <= '0;
              if (retry < RC_MAX) begin
                retry <= retry + RC_W'(1); state <= PWDN; pins_q <= pins(PWDN);
              end else begin
                state <= FAIL; pins_q <= pins(FAIL);
              end
            end else cnt <= cnt + ONE;
          end
        end
        SETTLE: if (cnt == SETTLE_LAST) begin
          state <= DONE; pins_q <= pins(DONE); cnt <= '0;
        end else cnt <= cnt + ONE;
        DONE, FAIL: if (start_in) begin
          state <= PWDN; pins_q <= pins(PWDN); cnt <= '0; retry <= '0;
        end
        default: begin
          state <= IDLE; pins_q <= pins(IDLE); cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_camera_init_sequencer.sv
// Bench for camera_init_sequencer: phase-level reference model compared every cycle,
// directed timing checks, randomized writer behaviour, and an AUTO_START=0 instance.
module tb_camera_init_sequencer;

  localparam int PW = 4, RS = 3, BT = 5, ST = 6, TO = 40, MR = 1;
  localparam int P_IDLE = 0, P_PWDN = 1, P_RESET = 2, P_BOOT = 3, P_REQ = 4,
                 P_RUN = 5, P_SETTLE = 6, P_DONE = 7, P_FAIL = 8;

  logic clk_in = 1'b0;
  logic rst_n = 1'b0, rst0_n = 1'b0;
  logic start = 1'b0, start0 = 1'b0;
  logic ready = 1'b0, ready0 = 1'b0;
  logic valid, pwdn, crst_n, busy, done, err;
  logic [0:0] rc;
  logic valid0, pwdn0, crst0_n, busy0, done0, err0;
  logic [0:0] rc0;

  int total = 0, bad = 0;
  int edge_n = -1;

  int m_ph = P_IDLE, m_age = 0, m_tmo = 0, m_retry = 0;
  bit m_seen = 1'b0;

  int wmode = 0, wlen = 20, low_cnt = 0;
  bit hs_done = 1'b0;

  logic [6:0] act_v, exp_v;

  always #5 clk_in = ~clk_in;

  camera_init_sequencer #(
    .PWDN_CYCLES(PW), .RESET_CYCLES(RS), .BOOT_CYCLES(BT), .SETTLE_CYCLES(ST),
    .TIMEOUT_CYCLES(TO), .MAX_RETRIES(MR), .AUTO_START(1)
  ) dut (
    .clk_in(clk_in), .rst_n_in(rst_n), .start_in(start),
    .init_valid_out(valid), .init_ready_in(ready),
    .cam_pwdn_out(pwdn), .cam_rst_n_out(crst_n),
    .busy_out(busy), .done_out(done), .error_out(err), .retry_count_out(rc)
  );

  camera_init_sequencer #(
    .PWDN_CYCLES(PW), .RESET_CYCLES(RS), .BOOT_CYCLES(BT), .SETTLE_CYCLES(ST),
    .TIMEOUT_CYCLES(TO), .MAX_RETRIES(MR), .AUTO_START(0)
  ) dut0 (
    .clk_in(clk_in), .rst_n_in(rst0_n), .start_in(start0),
    .init_valid_out(valid0), .init_ready_in(ready0),
    .cam_pwdn_out(pwdn0), .cam_rst_n_out(crst0_n),
    .busy_out(busy0), .done_out(done0), .error_out(err0), .retry_count_out(rc0)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at t=%0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model (phase + elapsed-cycle bookkeeping) ----------------
  function automatic int dur_of(input int p);
    case (p)
      P_PWDN:   return PW;
      P_RESET:  return RS;
      P_BOOT:   return BT;
      P_SETTLE: return ST;
      default:  return 1;
    endcase
  endfunction

  task automatic m_timeout();
    if (m_retry < MR) begin
      m_retry++; m_ph = P_PWDN; m_age = 0;
    end else begin
      m_ph = P_FAIL;
    end
  endtask

  task automatic m_step();
    case (m_ph)
      P_IDLE: begin m_ph = P_PWDN; m_age = 0; m_retry = 0; end
      P_DONE, P_FAIL: if (start) begin m_ph = P_PWDN; m_age = 0; m_retry = 0; end
      P_REQ: begin
        m_tmo++;
        if (ready) begin m_ph = P_RUN; m_seen = 1'b0; end
        else if (m_tmo >= TO) m_timeout();
      end
      P_RUN: begin
        m_tmo++;
        if (ready && m_seen) begin m_ph = P_SETTLE; m_age = 0; end
        else begin
          if (!ready) m_seen = 1'b1;
          if (m_tmo >= TO) m_timeout();
        end
      end
      default: begin
        m_age++;
        if (m_age == dur_of(m_ph)) begin
          m_ph++; m_age = 0;
          if (m_ph == P_REQ) m_tmo = 0;
        end
      end
    endcase
  endtask

  function automatic logic [6:0] m_expect();
    return {m_ph == P_REQ,
            (m_ph == P_IDLE || m_ph == P_PWDN || m_ph == P_FAIL),
            (m_ph >= P_BOOT && m_ph <= P_DONE),
            (m_ph >= P_PWDN && m_ph <= P_SETTLE),
            m_ph == P_DONE, m_ph == P_FAIL, 1'(m_retry)};
  endfunction

  initial forever begin
    @(posedge clk_in or negedge rst_n);
    if (!rst_n) begin
      m_ph = P_IDLE; m_age = 0; m_tmo = 0; m_retry = 0; m_seen = 1'b0;
    end else m_step();
  end

  initial forever begin
    @(posedge clk_in or negedge rst_n);
    if (!rst_n) edge_n = -1;
    else edge_n++;
  end

  initial forever begin
    @(negedge clk_in);
    act_v = {valid, pwdn, crst_n, busy, done, err, rc};
    exp_v = m_expect();
    chk("model", 32'(act_v), 32'(exp_v));
  end

  // Writer stand-in: 0 = drop ready wlen cycles after accept, 1 = stuck low,
  // 2 = random ready, 3 = never drops ready
  initial forever begin
    @(negedge clk_in);
    if (pwdn || !rst_n) begin hs_done = 1'b0; low_cnt = 0; end
    if (wmode == 2) ready = ($urandom_range(0, 3) != 0);
    else if (!hs_done) begin
      ready = 1'b1;
      if (valid) hs_done = 1'b1;
    end else if (wmode == 3) ready = 1'b1;
    else if (wmode == 1) ready = 1'b0;
    else if (low_cnt < wlen) begin ready = 1'b0; low_cnt++; end
    else ready = 1'b1;
  end

  task automatic to_edge(input int k);
    while (edge_n < k) @(negedge clk_in);
  endtask

  task automatic pulse_start(output int s);
    start = 1'b1;
    s = edge_n + 1;
    @(negedge clk_in);
    start = 1'b0;
  endtask

  task automatic wait_end(input int limit);
    int n;
    n = 0;
    while (!(done || err) && n < limit) begin @(negedge clk_in); n++; end
    chk("wait_end", 32'(done | err), 32'd1);
  endtask

  initial begin
    int s, r;
    // Reset state
    repeat (2) @(negedge clk_in);
    chk("reset_state", 32'({valid, pwdn, crst_n, busy, done, err, rc}), 32'b0100000);
    #2 rst_n = 1'b1;

    // Power sequence and nominal init (ready low 20 cycles after accept)
    to_edge(0);  chk("e0_pwdn", pwdn, 1); chk("e0_busy", busy, 1); chk("e0_rstn", crst_n, 0);
    to_edge(3);  chk("e3_pwdn", pwdn, 1);
    to_edge(4);  chk("e4_pwdn", pwdn, 0); chk("e4_rstn", crst_n, 0);
    to_edge(6);  chk("e6_rstn", crst_n, 0);
    to_edge(7);  chk("e7_rstn", crst_n, 1);
    to_edge(11); chk("e11_valid", valid, 0);
    to_edge(12); chk("e12_valid", valid, 1);
    to_edge(13); chk("e13_valid", valid, 0); chk("e13_busy", busy, 1);
    to_edge(39); chk("e39_done", done, 0);
    to_edge(40); chk("e40_done", done, 1); chk("e40_busy", busy, 0); chk("e40_rc", rc, 0);

    // Restart from DONE, with an ignored start pulse during BOOT
    pulse_start(s);
    chk("rs_done", done, 0); chk("rs_busy", busy, 1); chk("rs_pwdn", pwdn, 1);
    to_edge(s + 8);
    start = 1'b1; @(negedge clk_in); start = 1'b0;
    to_edge(s + 12); chk("rs_valid_up", valid, 1);
    to_edge(s + 13); chk("rs_valid_dn", valid, 0);
    to_edge(s + 39); chk("rs_done39", done, 0);
    to_edge(s + 40); chk("rs_done40", done, 1);

    // Timeout with retry, then FAIL
    wmode = 1;
    pulse_start(s);
    to_edge(s + 51);  chk("to1_pwdn_before", pwdn, 0); chk("to1_rc_before", rc, 0);
    to_edge(s + 52);  chk("to1_pwdn", pwdn, 1); chk("to1_rc", rc, 1); chk("to1_busy", busy, 1);
    to_edge(s + 103); chk("to2_err_before", err, 0);
    to_edge(s + 104);
    chk("to2_err", err, 1); chk("to2_busy", busy, 0); chk("to2_pwdn", pwdn, 1); chk("to2_rstn", crst_n, 0);

    // Restart from FAIL; ready never goes low so completion is never seen
    wmode = 3;
    pulse_start(s);
    chk("rf_rc", rc, 0); chk("rf_err", err, 0); chk("rf_busy", busy, 1);
    to_edge(s + 104); chk("nolow_err", err, 1);

    // Completion on the same cycle as timeout wins
    wmode = 0; wlen = 38;
    pulse_start(s);
    to_edge(s + 57); chk("tie_busy", busy, 1);
    to_edge(s + 58); chk("tie_done", done, 1); chk("tie_rc", rc, 0);

    // One cycle too late: timeout wins
    wlen = 39;
    pulse_start(s);
    to_edge(s + 52); chk("late_pwdn", pwdn, 1); chk("late_rc", rc, 1);
    wait_end(400);
    chk("late_err", err, 1);

    // Randomized writer behaviour with stray start pulses while busy
    for (int i = 0; i < 12; i++) begin
      wmode = $urandom_range(0, 3);
      wlen = $urandom_range(0, 45);
      pulse_start(s);
      r = $urandom_range(1, 60);
      repeat (r) @(negedge clk_in);
      if (busy) begin start = 1'b1; @(negedge clk_in); start = 1'b0; end
      wait_end(400);
    end

    // Asynchronous reset during the retry attempt's RUN phase
    wmode = 1;
    pulse_start(s);
    to_edge(s + 70); chk("ar_rc_before", rc, 1); chk("ar_busy_before", busy, 1);
    #2 rst_n = 1'b0;
    #1 chk("async_reset", 32'({valid, pwdn, crst_n, busy, done, err, rc}), 32'b0100000);
    @(negedge clk_in); @(negedge clk_in);
    wmode = 0; wlen = 5;
    #2 rst_n = 1'b1;
    to_edge(0); chk("ar_e0_busy", busy, 1); chk("ar_e0_pwdn", pwdn, 1);
    wait_end(200);
    chk("ar_done", done, 1);

    // AUTO_START=0 instance: waits in IDLE until start
    @(negedge clk_in);
    #2 rst0_n = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk_in);
      chk("idle0", 32'({pwdn0, crst0_n, busy0}), 32'b100);
    end
    start0 = 1'b1;
    @(negedge clk_in);
    start0 = 1'b0;
    chk("s0_busy", busy0, 1); chk("s0_pwdn", pwdn0, 1);
    repeat (3) @(negedge clk_in);
    chk("s0_pwdn3", pwdn0, 1);
    @(negedge clk_in);
    chk("s0_pwdn4", pwdn0, 0); chk("s0_rstn4", crst0_n, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
